// File: rtl/store_buf_pkg.sv
// ============================================================================
// Module  : store_buf_pkg
// Purpose : Shared types and helpers for the store buffer (entry layout, lane
//           count, WE-to-mask packing).
// Rev     : 1.0
// ============================================================================
`default_nettype none

package store_buf_pkg;

    localparam int NUM_LANES      = 4;
    localparam int SB_DATA_WIDTH  = NUM_LANES * 8;
    localparam int SB_WADDR_WIDTH = 30;

    typedef struct packed {
        logic                      valid;
        logic [SB_WADDR_WIDTH-1:0] word_addr;
        logic [SB_DATA_WIDTH-1:0]  data;
        logic [NUM_LANES-1:0]      we;
    } sb_entry_t;

    function automatic logic [NUM_LANES-1:0] pack_we(
        input logic we0,
        input logic we1,
        input logic we2,
        input logic we3
    );
        return {we3, we2, we1, we0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_if.sv
// ============================================================================
// Module  : store_buffer_if
// Purpose : Store/load/drain signal bundle between the pipeline, the store
//           buffer and data memory.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface store_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  WE0;
    logic                  WE1;
    logic                  WE2;
    logic                  WE3;
    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [3:0]            fwd_mask;
    logic                  mem_write;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_we;
    logic                  empty;
    logic                  full;

    modport slave (
        input  st_valid, st_addr, st_data, WE0, WE1, WE2, WE3,
        input  ld_valid, ld_addr, mem_ready,
        output st_ready, fwd_data, fwd_mask,
        output mem_write, mem_addr, mem_wdata, mem_we, empty, full
    );

    modport master (
        output st_valid, st_addr, st_data, WE0, WE1, WE2, WE3,
        output ld_valid, ld_addr, mem_ready,
        input  st_ready, fwd_data, fwd_mask,
        input  mem_write, mem_addr, mem_wdata, mem_we, empty, full
    );
endinterface

`default_nettype wire

// File: rtl/sb_fwd_merge.sv
// ============================================================================
// Module  : sb_fwd_merge
// Purpose : Per-lane store-to-load forwarding; scans entries oldest to youngest
//           so the youngest matching entry wins each lane.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sb_fwd_merge
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t                 entries_i [DEPTH],
    input  logic [PTR_W-1:0]          head_i,
    input  logic [SB_WADDR_WIDTH-1:0] ld_waddr_i,
    output logic [SB_DATA_WIDTH-1:0]  fwd_data_o,
    output logic [NUM_LANES-1:0]      fwd_mask_o
);

    logic [PTR_W-1:0] idx_w;

    always_comb begin
        fwd_data_o = '0;
        fwd_mask_o = '0;
        idx_w      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_w = head_i + PTR_W'(k);
            if (entries_i[idx_w].valid && (entries_i[idx_w].word_addr == ld_waddr_i)) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (entries_i[idx_w].we[l]) begin
                        fwd_data_o[8*l +: 8] = entries_i[idx_w].data[8*l +: 8];
                        fwd_mask_o[l]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module  : store_buffer
// Purpose : In-order store FIFO between the WE decoder and data memory; drains
//           when loads leave the port idle and forwards pending bytes to loads.
//           Define STORE_BUF_COALESCE_EN to merge same-word stores into tail-1.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t                 entries_q [DEPTH];
    sb_entry_t                 entries_d [DEPTH];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic [NUM_LANES-1:0]      st_we;
    logic [SB_WADDR_WIDTH-1:0] st_waddr;
    logic [SB_WADDR_WIDTH-1:0] ld_waddr;
    logic                      empty_w, full_w, ready_w, mem_write_w;
    logic                      push_req, alloc, coalesce, pop, coal_ok;
    logic [SB_DATA_WIDTH-1:0]  fwd_data_w;
    logic [NUM_LANES-1:0]      fwd_mask_w;
    logic                      unused_addr_lsbs;

    assign unused_addr_lsbs = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    assign st_we       = pack_we(sb.WE0, sb.WE1, sb.WE2, sb.WE3);
    assign st_waddr    = SB_WADDR_WIDTH'(sb.st_addr[ADDR_WIDTH-1:2]);
    assign ld_waddr    = SB_WADDR_WIDTH'(sb.ld_addr[ADDR_WIDTH-1:2]);
    assign empty_w     = (count_q == '0);
    assign full_w      = (count_q == CNT_W'(DEPTH));
    assign mem_write_w = !empty_w && !sb.ld_valid;
    assign pop         = mem_write_w && sb.mem_ready;

`ifdef STORE_BUF_COALESCE_EN
    logic [PTR_W-1:0] tail_prev;
    assign tail_prev = tail_q - PTR_W'(1);
    // The head being popped this cycle is leaving; merging into it would lose bytes.
    assign coal_ok   = entries_q[tail_prev].valid
                    && (entries_q[tail_prev].word_addr == st_waddr)
                    && !(pop && (tail_prev == head_q));
    assign ready_w   = !full_w || coal_ok;
`else
    assign coal_ok   = 1'b0;
    assign ready_w   = !full_w;
`endif

    assign push_req = sb.st_valid && ready_w && (|st_we);
    assign alloc    = push_req && !coal_ok;
    assign coalesce = push_req && coal_ok;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
        if (alloc) begin
            entries_d[tail_q] = '{valid:     1'b1,
                                  word_addr: st_waddr,
                                  data:      SB_DATA_WIDTH'(sb.st_data),
                                  we:        st_we};
            tail_d            = tail_q + PTR_W'(1);
        end
`ifdef STORE_BUF_COALESCE_EN
        if (coalesce) begin
            entries_d[tail_prev].we = entries_q[tail_prev].we | st_we;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (st_we[l]) begin
                    entries_d[tail_prev].data[8*l +: 8] = sb.st_data[8*l +: 8];
                end
            end
        end
`endif
        count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries_i  (entries_q),
        .head_i     (head_q),
        .ld_waddr_i (ld_waddr),
        .fwd_data_o (fwd_data_w),
        .fwd_mask_o (fwd_mask_w)
    );

    assign sb.st_ready  = ready_w;
    assign sb.empty     = empty_w;
    assign sb.full      = full_w;
    assign sb.mem_write = mem_write_w;
    assign sb.mem_addr  = empty_w ? '0
                        : {entries_q[head_q].word_addr[ADDR_WIDTH-3:0], 2'b00};
    assign sb.mem_wdata = empty_w ? '0 : DATA_WIDTH'(entries_q[head_q].data);
    assign sb.mem_we    = empty_w ? '0 : entries_q[head_q].we;
    assign sb.fwd_data  = DATA_WIDTH'(fwd_data_w);
    assign sb.fwd_mask  = fwd_mask_w;

    // The coalesce path is compiled out in the default build.
    logic unused_coalesce;
    assign unused_coalesce = coalesce;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module  : tb_store_buffer
// Purpose : Directed vector bench for store_buffer (DEPTH=4); expectations
//           adapt when STORE_BUF_COALESCE_EN is defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;
    import store_buf_pkg::*;

`ifdef STORE_BUF_COALESCE_EN
    localparam logic COAL = 1'b1;
`else
    localparam logic COAL = 1'b0;
`endif

    typedef struct {
        logic        rstn;
        logic        stv;
        logic [31:0] sta;
        logic [31:0] std;
        logic [3:0]  we;
        logic        ldv;
        logic [31:0] lda;
        logic        mr;
        logic        rdy;
        logic        emp;
        logic        ful;
        logic        mw;
        logic [31:0] ma;
        logic [3:0]  mwe;
        logic [31:0] mwd;
        logic [3:0]  fm;
        logic [31:0] fd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    store_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    store_buffer #(
        .DEPTH      (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic stv, input logic [31:0] sta, input logic [31:0] std, input logic [3:0] we,
        input logic ldv, input logic [31:0] lda, input logic mr,
        input logic rdy, input logic emp, input logic ful, input logic mw,
        input logic [31:0] ma, input logic [3:0] mwe, input logic [31:0] mwd,
        input logic [3:0] fm, input logic [31:0] fd
    );
        vec_t v;
        v.rstn = 1'b1; v.stv = stv; v.sta = sta; v.std = std; v.we = we;
        v.ldv = ldv; v.lda = lda; v.mr = mr;
        v.rdy = rdy; v.emp = emp; v.ful = ful; v.mw = mw;
        v.ma = ma; v.mwe = mwe; v.mwd = mwd; v.fm = fm; v.fd = fd;
        return v;
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", tag, name, act, exp);
        end
    endtask

    task automatic run(input string tag, input vec_t v);
        @(negedge clk);
        rst_n        = v.rstn;
        bus.st_valid = v.stv;
        bus.st_addr  = v.sta;
        bus.st_data  = v.std;
        {bus.WE3, bus.WE2, bus.WE1, bus.WE0} = v.we;
        bus.ld_valid = v.ldv;
        bus.ld_addr  = v.lda;
        bus.mem_ready = v.mr;
        #2;
        chk(tag, "st_ready",  32'(bus.st_ready),  32'(v.rdy));
        chk(tag, "empty",     32'(bus.empty),     32'(v.emp));
        chk(tag, "full",      32'(bus.full),      32'(v.ful));
        chk(tag, "mem_write", 32'(bus.mem_write), 32'(v.mw));
        chk(tag, "mem_addr",  bus.mem_addr,       v.ma);
        chk(tag, "mem_we",    32'(bus.mem_we),    32'(v.mwe));
        chk(tag, "mem_wdata", bus.mem_wdata,      v.mwd);
        chk(tag, "fwd_mask",  32'(bus.fwd_mask),  32'(v.fm));
        chk(tag, "fwd_data",  bus.fwd_data,       v.fd);
    endtask

    localparam logic [31:0] NA = 32'h0000_0500;
    localparam logic [31:0] DA = 32'hA0A0_A0A0;
    localparam logic [31:0] DB = 32'hB0B0_B0B0;
    localparam logic [31:0] DC = 32'hC0C0_C0C0;
    localparam logic [31:0] DD = 32'hD0D0_D0D0;
    localparam logic [31:0] DE = 32'hE0E0_E0E0;

    initial begin
        vec_t        tbl [22];
        vec_t        v;
        logic [3:0]  we_head;
        logic [31:0] wd_head;

        checks   = 0;
        failures = 0;
        we_head  = COAL ? 4'b0011 : 4'b0001;
        wd_head  = COAL ? 32'h0000_BBCC : 32'h0000_00AA;

        //            stv sta          std            we       ldv lda          mr  rdy emp ful mw  ma           mwe      mwd            fm       fd
        tbl[0]  = mk(0, 32'h0,       32'h0,         4'h0,    0, NA,          1,  1,  1,  0,  0,  32'h0,       4'h0,    32'h0,         4'h0,    32'h0);
        tbl[1]  = mk(1, 32'h100,     32'hDEADBEEF,  4'hF,    0, 32'h100,     1,  1,  1,  0,  0,  32'h0,       4'h0,    32'h0,         4'h0,    32'h0);
        tbl[2]  = mk(0, 32'h0,       32'h0,         4'h0,    0, 32'h100,     1,  1,  0,  0,  1,  32'h100,     4'hF,    32'hDEADBEEF,  4'hF,    32'hDEADBEEF);
        tbl[3]  = mk(0, 32'h0,       32'h0,         4'h0,    0, 32'h100,     1,  1,  1,  0,  0,  32'h0,       4'h0,    32'h0,         4'h0,    32'h0);
        tbl[4]  = mk(1, 32'h400,     DA,            4'hF,    1, NA,          1,  1,  1,  0,  0,  32'h0,       4'h0,    32'h0,         4'h0,    32'h0);
        tbl[5]  = mk(1, 32'h404,     DB,            4'hF,    1, NA,          1,  1,  0,  0,  0,  32'h400,     4'hF,    DA,            4'h0,    32'h0);
        tbl[6]  = mk(1, 32'h408,     DC,            4'hF,    1, NA,          1,  1,  0,  0,  0,  32'h400,     4'hF,    DA,            4'h0,    32'h0);
        tbl[7]  = mk(1, 32'h40C,     DD,            4'hF,    1, NA,          1,  1,  0,  0,  0,  32'h400,     4'hF,    DA,            4'h0,    32'h0);
        tbl[8]  = mk(1, 32'h410,     DE,            4'hF,    1, 32'h404,     1,  0,  0,  1,  0,  32'h400,     4'hF,    DA,            4'hF,    DB);
        tbl[9]  = mk(1, 32'h410,     DE,            4'hF,    0, NA,          1,  0,  0,  1,  1,  32'h400,     4'hF,    DA,            4'h0,    32'h0);
        tbl[10] = mk(1, 32'h410,     DE,            4'hF,    0, NA,          1,  1,  0,  0,  1,  32'h404,     4'hF,    DB,            4'h0,    32'h0);
        tbl[11] = mk(0, 32'h0,       32'h0,         4'h0,    0, 32'h410,     1,  1,  0,  0,  1,  32'h408,     4'hF,    DC,            4'hF,    DE);
        tbl[12] = mk(0, 32'h0,       32'h0,         4'h0,    0, NA,          1,  1,  0,  0,  1,  32'h40C,     4'hF,    DD,            4'h0,    32'h0);
        tbl[13] = mk(0, 32'h0,       32'h0,         4'h0,    0, NA,          0,  1,  0,  0,  1,  32'h410,     4'hF,    DE,            4'h0,    32'h0);
        tbl[14] = mk(0, 32'h0,       32'h0,         4'h0,    0, NA,          1,  1,  0,  0,  1,  32'h410,     4'hF,    DE,            4'h0,    32'h0);
        tbl[15] = mk(0, 32'h0,       32'h0,         4'h0,    0, NA,          1,  1,  1,  0,  0,  32'h0,       4'h0,    32'h0,         4'h0,    32'h0);
        tbl[16] = mk(1, 32'h200,     32'h000000AA,  4'b0001, 1, 32'h200,     1,  1,  1,  0,  0,  32'h0,       4'h0,    32'h0,         4'h0,    32'h0);
        tbl[17] = mk(1, 32'h200,     32'h0000BBCC,  4'b0011, 1, 32'h200,     1,  1,  0,  0,  0,  32'h200,     4'b0001, 32'h000000AA,  4'b0001, 32'h000000AA);
        tbl[18] = mk(0, 32'h0,       32'h0,         4'h0,    1, 32'h200,     1,  1,  0,  0,  0,  32'h200,     we_head, wd_head,       4'b0011, 32'h0000BBCC);
        tbl[19] = mk(0, 32'h0,       32'h0,         4'h0,    1, 32'h204,     1,  1,  0,  0,  0,  32'h200,     we_head, wd_head,       4'h0,    32'h0);
        tbl[20] = mk(1, 32'h600,     32'h12345678,  4'h0,    1, 32'h600,     1,  1,  0,  0,  0,  32'h200,     we_head, wd_head,       4'h0,    32'h0);
        tbl[21] = mk(0, 32'h0,       32'h0,         4'h0,    1, 32'h600,     1,  1,  0,  0,  0,  32'h200,     we_head, wd_head,       4'h0,    32'h0);

        rst_n = 1'b0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
        {bus.WE3, bus.WE2, bus.WE1, bus.WE0} = 4'h0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            run($sformatf("vec%0d", i), tbl[i]);
        end

        // Drain what the forwarding vectors left; the zero-mask store must not appear.
        run("drain0", mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 0, 0, 1, 32'h200, we_head, wd_head, 4'h0, 32'h0));
        if (COAL) v = mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 1, 0, 0, 32'h0,   4'h0,    32'h0,        4'h0, 32'h0);
        else      v = mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 0, 0, 1, 32'h200, 4'b0011, 32'h0000BBCC, 4'h0, 32'h0);
        run("drain1", v);
        run("drain2", mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 1, 0, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0));

        // Reset asserted while draining with three entries queued.
        run("rst0", mk(1, 32'h700, 32'h1, 4'hF, 1, NA, 1, 1, 1, 0, 0, 32'h0,   4'h0, 32'h0, 4'h0, 32'h0));
        run("rst1", mk(1, 32'h704, 32'h2, 4'hF, 1, NA, 1, 1, 0, 0, 0, 32'h700, 4'hF, 32'h1, 4'h0, 32'h0));
        run("rst2", mk(1, 32'h708, 32'h3, 4'hF, 1, NA, 1, 1, 0, 0, 0, 32'h700, 4'hF, 32'h1, 4'h0, 32'h0));
        v = mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 0, 0, 1, 32'h700, 4'hF, 32'h1, 4'h0, 32'h0);
        v.rstn = 1'b0;
        run("rst3", v);
        run("rst4", mk(0, 32'h0, 32'h0, 4'h0, 0, 32'h700, 1, 1, 1, 0, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0));

        // Two byte stores to one word: merged entry when coalescing, two entries otherwise.
        run("coal0", mk(1, 32'h300, 32'h00000011, 4'b0001, 1, 32'h300, 1, 1, 1, 0, 0, 32'h0,   4'h0,    32'h0,        4'h0,    32'h0));
        run("coal1", mk(1, 32'h301, 32'h00002200, 4'b0010, 1, 32'h300, 1, 1, 0, 0, 0, 32'h300, 4'b0001, 32'h00000011, 4'b0001, 32'h00000011));
        run("coal2", mk(0, 32'h0, 32'h0, 4'h0, 1, 32'h300, 1, 1, 0, 0, 0, 32'h300,
                        COAL ? 4'b0011 : 4'b0001, COAL ? 32'h00002211 : 32'h00000011, 4'b0011, 32'h00002211));
        run("coal3", mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 0, 0, 1, 32'h300,
                        COAL ? 4'b0011 : 4'b0001, COAL ? 32'h00002211 : 32'h00000011, 4'h0, 32'h0));
        if (COAL) v = mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 1, 0, 0, 32'h0,   4'h0,    32'h0,        4'h0, 32'h0);
        else      v = mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 0, 0, 1, 32'h300, 4'b0010, 32'h00002200, 4'h0, 32'h0);
        run("coal4", v);
        run("coal5", mk(0, 32'h0, 32'h0, 4'h0, 0, NA, 1, 1, 1, 0, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the write-enable decoder, between the execute/memory stage and data memory.
- Accepts stores that carry the decoder's byte-lane enables (WE3..WE0) and queues them in a small in-order FIFO.
- Drains queued stores to the data-memory write port whenever loads are not using that port; loads always have priority.
- Forwards pending store bytes to same-word loads so loads never read stale memory.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; fixed at 4 byte lanes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- st_valid  in  1  store request this cycle.
- st_ready  out  1  buffer can accept a store; equals !full.
- st_addr  in  ADDR_WIDTH  store byte address; word index is st_addr[ADDR_WIDTH-1:2].
- st_data  in  DATA_WIDTH  store data, already lane-aligned.
- WE0, WE1, WE2, WE3  in  1 each  byte-lane enables from the decoder.
- ld_valid  in  1  load using the memory port this cycle.
- ld_addr  in  ADDR_WIDTH  load byte address.
- fwd_data  out  DATA_WIDTH  merged forwarded bytes.
- fwd_mask  out  4  per-lane forward hit.
- mem_write  out  1  drain request.
- mem_ready  in  1  memory accepts a drain this cycle.
- mem_addr  out  ADDR_WIDTH  head entry word address, with bits [1:0] driven as 0.
- mem_wdata  out  DATA_WIDTH  head entry data.
- mem_we  out  4  head entry lane enables {WE3..WE0}.
- empty, full  out  1 each  occupancy flags.

Behaviour:
- Reset (rst_n=0 at an edge):
  - head, tail and count go to 0; all entry valid bits cleared.
  - Pending stores are discarded, including during a drain.
  - After reset: empty=1, full=0, st_ready=1, mem_write=0, fwd_mask=0.
  - fwd_data=0, mem_addr=0, mem_wdata=0, mem_we=0.
- Push:
  - Occurs when st_valid && st_ready && (WE3|WE2|WE1|WE0).
  - Entry written at tail with {word address, data, lane mask}; tail increments and wraps modulo DEPTH.
  - st_valid with an all-zero mask (illegal funct3) is silently dropped: no entry, no error, st_ready unaffected.
  - st_valid while full is not accepted; upstream must hold the store.
- Drain:
  - mem_write = !empty && !ld_valid, combinational.
  - mem_addr, mem_wdata and mem_we always reflect the head entry; all zero when empty.
  - Pop on mem_write && mem_ready: head increments and wraps.
  - mem_ready low holds the head entry stable.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with a pop in the same cycle: st_ready stays 0, with no same-cycle bypass. The freed slot is usable next cycle.
- Count: width $clog2(DEPTH)+1. full = (count==DEPTH); empty = (count==0).
- Forwarding (combinational, zero latency):
  - Scan all valid entries whose word address equals ld_addr word index.
  - For each lane, take the byte from the youngest matching entry that enables that lane, and set its fwd_mask bit.
  - Lanes with no hit give fwd_mask=0 and fwd_data byte=0.
  - Pending pushes in the same cycle are not forwarded.
  - An entry popping in the same cycle still forwards.
  - Forwarding outputs are valid regardless of ld_valid.
- Stores drain in program order. Load data ordering follows the rule above; the consumer merges fwd_data over memory read data using fwd_mask.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined:
  - A store coalesces into the tail-1 entry when it matches that entry's word address, the entry is valid, and the entry is not the head being popped that cycle.
  - Coalescing ORs the lane masks and overwrites the enabled bytes; no new entry is allocated.
  - Coalescing is allowed even when full, so st_ready = !full || coalesce-possible.
- Undefined: every accepted store allocates a new entry.

Decomposition:
- Package store_buf_pkg:
  - sb_entry_t struct {valid, word_addr, data, we[3:0]}.
  - Constant NUM_LANES=4.
  - Function to pack WE0..WE3 into a 4-bit mask.
- One sub-module, sb_fwd_merge: takes the entry array, head pointer and ld word address, and produces fwd_data and fwd_mask using youngest-wins age ordering.

Test Plan:
- Reset then idle -> empty=1, st_ready=1, mem_write=0; no drain with mem_ready=1.
- sw 0x100 data 0xDEADBEEF (mask 1111), ld_valid=0, mem_ready=1 -> next cycle mem_write=1, mem_addr=0x100, mem_we=1111; empty afterwards.
- Fill 4 stores with ld_valid=1 -> full=1, st_ready=0, fifth store held; drop ld_valid -> drains in push order, one per cycle.
- sb 0x200 0x000000AA, then sh 0x200 0x0000BBCC, ld_addr=0x200 -> fwd_mask=0011, fwd_data=0x0000BBCC (younger wins).
- Store with all WE=0 -> not enqueued, count unchanged; rst_n low mid-drain with 3 entries -> next cycle empty=1, mem_write=0.
- With STORE_BUF_COALESCE_EN: sb 0x300 lane0 0x11, then sb 0x301-lane1 store to the same word -> single entry with mem_we=0011.
